reg_file: RTL

Architectural register file with per-register rename tags. It sits directly downstream of the reorder buffer's commit port and beside the issue stage. The ROB's commit outputs (enable, index, ROB id, value, jump flag) write retired results here. The issue stage renames destinations and reads operand value/tag pairs with same-cycle commit bypass.

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_read_port.sv | 44 ++++
 rtl/reg_file.sv | 99 +++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths and helpers for the architectural register file and its read ports.
package reg_file_pkg;

  localparam int XLEN        = 32;
  localparam int REG_IDX_W   = 5;
  localparam int ROB_LOG_DEF = 4;

  // x0 and indices beyond the implemented register count never carry state.
  function automatic logic idx_live(input logic [REG_IDX_W-1:0] idx, input int reg_num);
    return (idx != '0) && (int'(idx) < reg_num);
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational operand read port: index decode, x0 masking and same-cycle commit bypass.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int ROB_LOG = ROB_LOG_DEF,
  parameter int REG_NUM = 32
) (
  input  logic [REG_IDX_W-1:0]             idx_i,
  input  logic                             rdy_i,
  input  logic [REG_NUM-1:0]               busy_i,
  input  logic [REG_NUM-1:0][ROB_LOG-1:0]  tag_i,
  input  logic [REG_NUM-1:0][XLEN-1:0]     value_i,
  input  logic                             commit_valid_i,
  input  logic [REG_IDX_W-1:0]             commit_index_i,
  input  logic [ROB_LOG-1:0]               commit_rob_id_i,
  input  logic [XLEN-1:0]                  commit_value_i,
  output logic                             busy_o,
  output logic [ROB_LOG-1:0]               rob_id_o,
  output logic [XLEN-1:0]                  value_o
);

  logic bypass;

  always_comb begin
    busy_o   = 1'b0;
    rob_id_o = '0;
    value_o  = '0;
    bypass   = 1'b0;
    if (idx_live(idx_i, REG_NUM)) begin
      // Only the commit that retires the current mapping may forward its value.
      bypass = rdy_i && commit_valid_i && (commit_index_i == idx_i) &&
               busy_i[idx_i] && (tag_i[idx_i] == commit_rob_id_i);
      rob_id_o = tag_i[idx_i];
      if (bypass) begin
        busy_o  = 1'b0;
        value_o = commit_value_i;
      end else begin
        busy_o  = busy_i[idx_i];
        value_o = value_i[idx_i];
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags: commit writes from the ROB, rename from issue,
// two bypassing operand read ports.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_LOG = ROB_LOG_DEF,
  parameter int REG_NUM = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rdy_i,
  input  logic                  flush_i,
  input  logic                  commit_valid_i,
  input  logic [REG_IDX_W-1:0]  commit_index_i,
  input  logic [ROB_LOG-1:0]    commit_rob_id_i,
  input  logic [XLEN-1:0]       commit_value_i,
  input  logic                  issue_valid_i,
  input  logic [REG_IDX_W-1:0]  issue_dest_i,
  input  logic [ROB_LOG-1:0]    issue_rob_id_i,
  input  logic [REG_IDX_W-1:0]  rs1_index_i,
  input  logic [REG_IDX_W-1:0]  rs2_index_i,
  output logic                  rs1_busy_o,
  output logic [ROB_LOG-1:0]    rs1_rob_id_o,
  output logic [XLEN-1:0]       rs1_value_o,
  output logic                  rs2_busy_o,
  output logic [ROB_LOG-1:0]    rs2_rob_id_o,
  output logic [XLEN-1:0]       rs2_value_o
);

  logic [REG_NUM-1:0]              busy_q,  busy_d;
  logic [REG_NUM-1:0][ROB_LOG-1:0] tag_q,   tag_d;
  logic [REG_NUM-1:0][XLEN-1:0]    value_q, value_d;

  always_comb begin
    busy_d  = busy_q;
    tag_d   = tag_q;
    value_d = value_q;
    if (rdy_i) begin
      // Entry 0 is never touched, so x0 holds its reset state forever.
      for (int i = 1; i < REG_NUM; i++) begin
        if (commit_valid_i && (commit_index_i == REG_IDX_W'(i))) begin
          value_d[i] = commit_value_i;
        end
        if (flush_i) begin
          busy_d[i] = 1'b0;
        end else if (issue_valid_i && (issue_dest_i == REG_IDX_W'(i))) begin
          busy_d[i] = 1'b1;
          tag_d[i]  = issue_rob_id_i;
        end else if (commit_valid_i && (commit_index_i == REG_IDX_W'(i)) &&
                     (tag_q[i] == commit_rob_id_i)) begin
          busy_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= '0;
      tag_q   <= '0;
      value_q <= '0;
    end else begin
      busy_q  <= busy_d;
      tag_q   <= tag_d;
      value_q <= value_d;
    end
  end

  reg_read_port #(.ROB_LOG(ROB_LOG), .REG_NUM(REG_NUM)) u_rs1_port (
    .idx_i           (rs1_index_i),
    .rdy_i           (rdy_i),
    .busy_i          (busy_q),
    .tag_i           (tag_q),
    .value_i         (value_q),
    .commit_valid_i  (commit_valid_i),
    .commit_index_i  (commit_index_i),
    .commit_rob_id_i (commit_rob_id_i),
    .commit_value_i  (commit_value_i),
    .busy_o          (rs1_busy_o),
    .rob_id_o        (rs1_rob_id_o),
    .value_o         (rs1_value_o)
  );

  reg_read_port #(.ROB_LOG(ROB_LOG), .REG_NUM(REG_NUM)) u_rs2_port (
    .idx_i           (rs2_index_i),
    .rdy_i           (rdy_i),
    .busy_i          (busy_q),
    .tag_i           (tag_q),
    .value_i         (value_q),
    .commit_valid_i  (commit_valid_i),
    .commit_index_i  (commit_index_i),
    .commit_rob_id_i (commit_rob_id_i),
    .commit_value_i  (commit_value_i),
    .busy_o          (rs2_busy_o),
    .rob_id_o        (rs2_rob_id_o),
    .value_o         (rs2_value_o)
  );

endmodule
